// File: rtl/clk_sel_pkg.sv
// Shared constants for the clock-select control slice: FSM encoding, select
// encoding and default timing parameters.
package clk_sel_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  localparam int SETTLE_CYCLES_DEF = 16;
  localparam int MIN_DWELL_DEF     = 1024;

  localparam logic SEL_CLK1 = 1'b0;
  localparam logic SEL_CLK2 = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and enable; reset loads MAX so
// the count starts out already saturated.
module sat_counter #(
  parameter int W   = 16,
  parameter int MAX = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= W'(MAX);
    else if (clr)
      cnt <= '0;
    else if (en && (cnt < W'(MAX)))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/clk_sel_ctrl.sv
// Rate-limited select control feeding the glitch-free two-clock mux.
// Define CLK_SEL_STATS_EN to build the completed-switch counter (switch_cnt).
module clk_sel_ctrl
  import clk_sel_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int MIN_DWELL     = MIN_DWELL_DEF,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_sel,
  output logic       req_ready,
  output logic       sel,
  output logic       cur_sel,
  output logic       busy,
  output logic       switch_done,
  output logic [7:0] switch_cnt
);

  logic [1:0]       state;
  logic             target;
  logic [CNT_W-1:0] settle_cnt;
  logic [CNT_W-1:0] dwell_cnt;
  logic             hs;
  logic             dwell_ok;
  logic             settle_last;
  logic             real_done;

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign hs          = req_valid && req_ready;
  assign dwell_ok    = (dwell_cnt >= CNT_W'(MIN_DWELL));
  assign settle_last = (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign real_done   = (state == SETTLE) && settle_last;

  // Dwell runs from the last completion; frozen while the mux is settling.
  sat_counter #(.W(CNT_W), .MAX(MIN_DWELL)) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr (real_done),
    .en  (state != SETTLE),
    .cnt (dwell_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= SEL_CLK1;
      cur_sel     <= SEL_CLK1;
      target      <= SEL_CLK1;
      settle_cnt  <= '0;
      switch_done <= 1'b0;
    end else begin
      switch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            if (req_sel == cur_sel) begin
              switch_done <= 1'b1;
            end else begin
              target <= req_sel;
              state  <= HOLD;
            end
          end
        end
        HOLD: begin
          if (dwell_ok) begin
            sel        <= target;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + CNT_W'(1);
          if (settle_last) begin
            state       <= IDLE;
            cur_sel     <= sel;
            switch_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLK_SEL_STATS_EN
  logic [7:0] stat_cnt;

  // No-op completions never pass through SETTLE, so they are not counted.
  always_ff @(posedge clk) begin
    if (rst)
      stat_cnt <= '0;
    else if (real_done)
      stat_cnt <= stat_cnt + 8'd1;
  end

  assign switch_cnt = stat_cnt;
`else
  assign switch_cnt = '0;
`endif

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Self-checking bench for clk_sel_ctrl (SETTLE_CYCLES=4, MIN_DWELL=8): vector
// table, directed corner sequences and random traffic against an event-time model.
module tb_clk_sel_ctrl;

  localparam int SETTLE = 4;
  localparam int DWELL  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_sel = 1'b0;
  logic       req_ready, sel, cur_sel, busy, switch_done;
  logic [7:0] switch_cnt;

  clk_sel_ctrl #(.SETTLE_CYCLES(SETTLE), .MIN_DWELL(DWELL), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_sel     (req_sel),
    .req_ready   (req_ready),
    .sel         (sel),
    .cur_sel     (cur_sel),
    .busy        (busy),
    .switch_done (switch_done),
    .switch_cnt  (switch_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: switches are scheduled as absolute edge numbers.
  logic m_sel, m_cur, m_busy, m_done, m_tgt, acc;
  int   m_sel_e, m_done_e, m_last, m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s);
    int exp_cnt;
    rst = r; req_valid = v; req_sel = s;
    @(posedge clk);
    cyc++;
    acc = 1'b0;
    if (r) begin
      m_sel = 0; m_cur = 0; m_busy = 0; m_done = 0; m_cnt = 0;
      m_last = -100000;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (v) begin
          acc = 1'b1;
          if (s == m_cur) m_done = 1;
          else begin
            m_busy   = 1;
            m_tgt    = s;
            m_sel_e  = (cyc + 1 > m_last + DWELL + 1) ? cyc + 1 : m_last + DWELL + 1;
            m_done_e = m_sel_e + SETTLE;
          end
        end
      end else begin
        if (cyc == m_sel_e) m_sel = m_tgt;
        if (cyc == m_done_e) begin
          m_cur  = m_sel;
          m_busy = 0;
          m_done = 1;
          m_last = cyc;
          m_cnt  = (m_cnt + 1) % 256;
        end
      end
    end
    #1;
`ifdef CLK_SEL_STATS_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    chk("m_sel", sel, m_sel);
    chk("m_cur_sel", cur_sel, m_cur);
    chk("m_busy", busy, m_busy);
    chk("m_req_ready", req_ready, !m_busy);
    chk("m_switch_done", switch_done, m_done);
    chk("m_switch_cnt", switch_cnt, exp_cnt);
  endtask

  // Present a request until accepted, then idle until its switch_done.
  task automatic do_switch(input logic s, output int done_e);
    int n;
    done_e = -1;
    n = 0;
    do begin step(1'b0, 1'b1, s); n++; end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", 0, 1);
    n = 0;
    while (!switch_done && n < 200) begin step(1'b0, 1'b0, 1'b0); n++; end
    if (switch_done) done_e = cyc;
    else chk("done_timeout", 0, 1);
  endtask

  typedef struct {
    logic r, v, s;
    logic e_sel, e_cur, e_busy, e_done;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int de, se, ae, n, dones, exp3, exp257;
    logic pre;

    tbl[0] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 1, 0, 0, 1, 0};
    tbl[2] = '{0, 0, 0, 1, 0, 1, 0};
    tbl[3] = '{0, 0, 0, 1, 0, 1, 0};
    tbl[4] = '{0, 0, 0, 1, 0, 1, 0};
    tbl[5] = '{0, 0, 0, 1, 0, 1, 0};
    tbl[6] = '{0, 0, 0, 1, 1, 0, 1};
    tbl[7] = '{0, 0, 0, 1, 1, 0, 0};
    tbl[8] = '{0, 1, 1, 1, 1, 0, 1};
    tbl[9] = '{0, 0, 0, 1, 1, 0, 0};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].s);
      chk($sformatf("tbl%0d_sel", i), sel, tbl[i].e_sel);
      chk($sformatf("tbl%0d_cur", i), cur_sel, tbl[i].e_cur);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_ready", i), req_ready, !tbl[i].e_busy);
      chk($sformatf("tbl%0d_done", i), switch_done, tbl[i].e_done);
    end

    // Back-to-back request right after a done waits out the dwell.
    step(1'b1, 1'b0, 1'b0);
    do_switch(1'b1, de);
    step(1'b0, 1'b1, 1'b0);
    chk("dwell_accept", acc, 1);
    se = -1; n = 0;
    while (sel != 1'b0 && n < 50) begin step(1'b0, 1'b0, 1'b0); n++; end
    if (sel == 1'b0) se = cyc;
    chk("dwell_sel_gap", se - de, DWELL + 1);
    n = 0;
    while (!switch_done && n < 50) begin step(1'b0, 1'b0, 1'b0); n++; end
    chk("dwell_done_gap", cyc - se, SETTLE);

    // Request held through SETTLE is taken on the first IDLE cycle.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    de = -1; ae = -1; n = 0;
    do begin
      pre = req_ready;
      step(1'b0, 1'b1, 1'b0);
      if (switch_done) de = cyc;
      if (pre) ae = cyc;
      n++;
    end while (ae < 0 && n < 50);
    chk("held_accept_gap", ae - de, 1);
    step(1'b0, 1'b0, 1'b0);
    chk("held_busy_after", busy, 1);

    // Reset in the second SETTLE cycle aborts without a done pulse.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("abort_sel", sel, 0);
    chk("abort_cur", cur_sel, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", req_ready, 1);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (switch_done) dones++;
    end
    chk("abort_no_done", dones, 0);

    // Switch statistics.
`ifdef CLK_SEL_STATS_EN
    exp3 = 3; exp257 = 1;
`else
    exp3 = 0; exp257 = 0;
`endif
    do_switch(1'b1, de);
    do_switch(1'b1, de);
    do_switch(1'b0, de);
    do_switch(1'b0, de);
    do_switch(1'b1, de);
    chk("stats_3real_2noop", switch_cnt, exp3);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 257; i++) do_switch(i[0] ? 1'b0 : 1'b1, de);
    chk("stats_wrap_257", switch_cnt, exp257);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
